// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - keypad responder shared types, constants and key position map
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Bit indices on the active-low buses: row[3] is the top row, col[3] the leftmost column
    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    // Physical layout, top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
    function automatic key_pos_t key_to_pos(input logic [3:0] key);
        key_pos_t pos;
        case (key)
            4'h1:    pos = '{row: 2'd3, col: 2'd3};
            4'h2:    pos = '{row: 2'd3, col: 2'd2};
            4'h3:    pos = '{row: 2'd3, col: 2'd1};
            4'hA:    pos = '{row: 2'd3, col: 2'd0};
            4'h4:    pos = '{row: 2'd2, col: 2'd3};
            4'h5:    pos = '{row: 2'd2, col: 2'd2};
            4'h6:    pos = '{row: 2'd2, col: 2'd1};
            4'hB:    pos = '{row: 2'd2, col: 2'd0};
            4'h7:    pos = '{row: 2'd1, col: 2'd3};
            4'h8:    pos = '{row: 2'd1, col: 2'd2};
            4'h9:    pos = '{row: 2'd1, col: 2'd1};
            4'hC:    pos = '{row: 2'd1, col: 2'd0};
            4'h0:    pos = '{row: 2'd0, col: 2'd3};
            4'hF:    pos = '{row: 2'd0, col: 2'd2};
            4'hE:    pos = '{row: 2'd0, col: 2'd1};
            default: pos = '{row: 2'd0, col: 2'd0};
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/keypad_responder_if.sv
// rtl/keypad_responder_if.sv - keypad scan lines plus key injection handshake
interface keypad_responder_if;
    logic [3:0] col;
    logic [3:0] row;
    logic       inject_valid;
    logic [3:0] inject_key;
    logic       ready;
    logic       pressed;
    logic       done;

    modport master (
        output col, inject_valid, inject_key,
        input  row, ready, pressed, done
    );

    modport slave (
        input  col, inject_valid, inject_key,
        output row, ready, pressed, done
    );
endinterface

// File: rtl/keypad_bounce_gen.sv
// rtl/keypad_bounce_gen.sv - contact bounce pattern at press start (built only with KEYPAD_BOUNCE_EN)
`ifdef KEYPAD_BOUNCE_EN
module keypad_bounce_gen #(
    parameter int CNT_W         = 24,
    parameter int BOUNCE_CYCLES = 20_000,
    parameter int BOUNCE_PERIOD = 1_000
) (
    input  logic [CNT_W-1:0] count,
    output logic             contact
);
    logic [CNT_W-1:0] slot;

    // Contact starts closed and flips every BOUNCE_PERIOD counts, then stays closed
    always_comb begin
        slot    = count / CNT_W'(BOUNCE_PERIOD);
        contact = 1'b1;
        if (count < CNT_W'(BOUNCE_CYCLES)) begin
            contact = ~slot[0];
        end
    end
endmodule
`endif

// File: rtl/keypad_responder.sv
// rtl/keypad_responder.sv - PmodKYPD responder emulator; optional bounce via KEYPAD_BOUNCE_EN
module keypad_responder
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES    = 1_000_000,
    parameter int RELEASE_CYCLES = 500_000,
    parameter int BOUNCE_CYCLES  = 20_000,
    parameter int BOUNCE_PERIOD  = 1_000,
    parameter int CNT_W          = 24
) (
    input  logic                clk,
    input  logic                Rst,
    keypad_responder_if.slave   kp
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       key_q, key_d;
    logic             done;
    logic             contact;
    logic             pressed;
    logic [3:0]       row;
    key_pos_t         pos;

    // Phase register; async reset drops the key immediately
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            count_q <= '0;
            key_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            key_q   <= key_d;
        end
    end

    // Phase sequencing: counter compared against terminal count, cleared on every transition
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        key_d   = key_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (kp.inject_valid) begin
                    state_d = PRESS;
                    count_d = '0;
                    key_d   = kp.inject_key;
                end
            end
            PRESS: begin
                if (count_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = RELEASE;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (count_q == CNT_W'(RELEASE_CYCLES - 1)) begin
                    state_d = IDLE;
                    count_d = '0;
                    done    = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

`ifdef KEYPAD_BOUNCE_EN
    keypad_bounce_gen #(
        .CNT_W         (CNT_W),
        .BOUNCE_CYCLES (BOUNCE_CYCLES),
        .BOUNCE_PERIOD (BOUNCE_PERIOD)
    ) u_bounce (
        .count   (count_q),
        .contact (contact)
    );
`else
    // Bounce settings only matter when the bounce generator is built
    logic unused_bounce_cfg;
    assign unused_bounce_cfg = ^{32'(BOUNCE_CYCLES), 32'(BOUNCE_PERIOD)};
    assign contact = 1'b1;
`endif

    // Row answer is combinational from the strobes so the scanner sees zero latency
    always_comb begin
        pos     = key_to_pos(key_q);
        pressed = (state_q == PRESS) && contact;
        row     = 4'hF;
        if (pressed && !kp.col[pos.col]) begin
            row[pos.row] = 1'b0;
        end
    end

    assign kp.row     = row;
    assign kp.ready   = (state_q == IDLE);
    assign kp.pressed = pressed;
    assign kp.done    = done;
endmodule

// File: tb/tb_keypad_responder.sv
// tb/tb_keypad_responder.sv - randomized self-checking bench for keypad_responder
module tb_keypad_responder;
    localparam int HOLD   = 20;
    localparam int REL    = 10;
    localparam int BOUNCE = 8;
    localparam int PERIOD = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keypad_responder_if kp_if ();

    keypad_responder #(
        .HOLD_CYCLES    (HOLD),
        .RELEASE_CYCLES (REL),
        .BOUNCE_CYCLES  (BOUNCE),
        .BOUNCE_PERIOD  (PERIOD),
        .CNT_W          (24)
    ) dut (
        .clk (clk),
        .Rst (rst),
        .kp  (kp_if)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: key position from the printed keypad layout, timing from cycles since acceptance
    int layout [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};
    int         n        = 0;
    int         n_a      = 0;
    bit         m_active = 1'b0;
    logic [3:0] m_key    = 4'h0;
    int         last_done = -1;
    int         last_rise = -1;
    logic       prev_pressed = 1'b0;

    function automatic int m_elapsed();
        return n - n_a;
    endfunction

    function automatic bit m_idle();
        return !m_active || (m_elapsed() >= HOLD + REL);
    endfunction

    function automatic bit m_contact(input int e);
`ifdef KEYPAD_BOUNCE_EN
        if (e < BOUNCE) return ((e / PERIOD) % 2) == 0;
`endif
        return 1'b1;
    endfunction

    function automatic bit m_pressed();
        return m_active && (m_elapsed() < HOLD) && m_contact(m_elapsed());
    endfunction

    function automatic bit m_done();
        return m_active && (m_elapsed() == HOLD + REL - 1);
    endfunction

    function automatic logic [3:0] m_row(input logic [3:0] c);
        logic [3:0] res;
        res = 4'hF;
        for (int ti = 0; ti < 4; ti++) begin
            for (int li = 0; li < 4; li++) begin
                if (layout[ti][li] == int'(m_key) && m_pressed() && c[3 - li] == 1'b0) begin
                    res[3 - ti] = 1'b0;
                end
            end
        end
        return res;
    endfunction

    task automatic model_step(input logic v, input logic [3:0] k);
        bit idle_before;
        if (rst) begin
            n++;
            m_active = 1'b0;
        end else begin
            idle_before = m_idle();
            n++;
            if (idle_before && v) begin
                m_active = 1'b1;
                n_a      = n;
                m_key    = k;
            end
        end
    endtask

    task automatic cycle(input logic [3:0] c, input logic v, input logic [3:0] k, input string tag);
        @(negedge clk);
        kp_if.col          = c;
        kp_if.inject_valid = v;
        kp_if.inject_key   = k;
        #1;
        check({tag, ".row"},     kp_if.row,     m_row(c));
        check({tag, ".ready"},   kp_if.ready,   m_idle());
        check({tag, ".pressed"}, kp_if.pressed, m_pressed());
        check({tag, ".done"},    kp_if.done,    m_done());
        if (kp_if.done === 1'b1) last_done = n;
        if (kp_if.pressed === 1'b1 && prev_pressed !== 1'b1) last_rise = n;
        prev_pressed = kp_if.pressed;
        @(posedge clk);
        model_step(v, k);
    endtask

    logic [3:0] sweep [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    int         acc_n;

    initial begin
        rst                = 1'b1;
        kp_if.col          = 4'b0111;
        kp_if.inject_valid = 1'b0;
        kp_if.inject_key   = 4'h0;
        #2;
        check("reset.row",     kp_if.row,     4'hF);
        check("reset.ready",   kp_if.ready,   1'b1);
        check("reset.pressed", kp_if.pressed, 1'b0);
        check("reset.done",    kp_if.done,    1'b0);
        @(posedge clk);
        model_step(1'b0, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        // Key 5 under a rotating column sweep, through to idle
        acc_n = n;
        cycle(4'b0111, 1'b1, 4'h5, "k5");
        for (int i = 0; i < HOLD + REL + 2; i++) cycle(sweep[i % 4], 1'b0, 4'h0, "k5");
        check("k5.done_latency", last_done - acc_n, HOLD + REL);

        // Key D, with a second injection during PRESS that must be ignored
        cycle(4'b1110, 1'b1, 4'hD, "kd");
        for (int i = 0; i < 5; i++) cycle(4'b1110, 1'b0, 4'h0, "kd");
        cycle(4'b1110, 1'b1, 4'h1, "kd_ign");
        for (int i = 0; i < HOLD + REL; i++) cycle(4'b1110, 1'b0, 4'h1, "kd");

        // Reset during press cycle 7
        cycle(4'b1011, 1'b1, 4'h6, "rst_mid");
        for (int i = 0; i < 6; i++) cycle(4'b1101, 1'b0, 4'h0, "rst_mid");
        check("rst_mid.e", m_elapsed(), 6);
        @(negedge clk);
        kp_if.col = 4'b1101;
        rst = 1'b1;
        #1;
        check("rst_mid.row",     kp_if.row,     4'hF);
        check("rst_mid.pressed", kp_if.pressed, 1'b0);
        check("rst_mid.done",    kp_if.done,    1'b0);
        check("rst_mid.ready",   kp_if.ready,   1'b1);
        @(posedge clk);
        model_step(1'b0, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        cycle(4'b0111, 1'b1, 4'h0, "after_rst");

        // Key 0 on the leftmost column exercises the bounce window when enabled
        for (int i = 0; i < HOLD + REL + 1; i++) cycle(4'b0111, 1'b0, 4'h0, "k0");

        // Back-to-back: valid held, next acceptance one cycle after done
        for (int i = 0; i < 2 * (HOLD + REL) + 4; i++) cycle(4'b1110, 1'b1, 4'hA, "b2b");
        check("b2b.gap", last_rise - last_done, 2);

        // Random scan patterns and sparse injections
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
